// File: rtl/chart_play_sequencer.sv
// chart_play_sequencer: requests a chart, steps its note slots at a fixed tick rate and scores the player keys.
// Optional combo scoring is enabled by defining CHART_PLAY_COMBO_EN.
`default_nettype none

module chart_play_sequencer #(
  parameter int NOTE_W     = 9,
  parameter int IDX_W      = 9,
  parameter int TICK_DIV   = 10000000,
  parameter int LOAD_CYC   = 2,
  parameter int SCORE_W    = 16,
  parameter int HIT_POINTS = 10
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [7:0]         chart_id,
  input  logic               abort,
  input  logic [IDX_W-1:0]   note_cnt,
  input  logic [NOTE_W-1:0]  note_data,
  input  logic [NOTE_W-1:0]  keys_in,
  output logic [7:0]         read_chart_id,
  output logic [IDX_W-1:0]   note_idx,
  output logic [NOTE_W-1:0]  cur_note,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]   hit_cnt,
  output logic [IDX_W-1:0]   miss_cnt,
  output logic [IDX_W-1:0]   max_combo
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LD_W   = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [LD_W-1:0]   LD_LAST   = LD_W'(LOAD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PLAY   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LD_W-1:0]     ld_q, ld_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          rd_id_q, rd_id_d;
  logic [NOTE_W-1:0]   cur_note_q, cur_note_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [IDX_W-1:0]    hit_q, hit_d;
  logic [IDX_W-1:0]    miss_q, miss_d;

  logic                w_eval;
  logic                w_last;
  logic                w_hit;
  logic [SCORE_W-1:0]  w_points;
  logic [SCORE_W:0]    w_sum;

`ifdef CHART_PLAY_COMBO_EN
  logic [IDX_W-1:0]    combo_q, combo_d;
  logic [IDX_W-1:0]    maxc_q, maxc_d;
  logic [IDX_W-1:0]    w_bonus;

  // Streak bonus is capped at 8 extra points per hit.
  assign w_bonus  = (combo_q > IDX_W'(8)) ? IDX_W'(8) : combo_q;
  assign w_points = SCORE_W'(HIT_POINTS) + SCORE_W'(w_bonus);
`else
  assign w_points = SCORE_W'(HIT_POINTS);
`endif

  assign w_eval = (tick_q == TICK_LAST);
  assign w_last = (idx_q == (cnt_q - IDX_W'(1)));
  assign w_hit  = (note_data != '0) && (keys_in == note_data);
  assign w_sum  = {1'b0, score_q} + {1'b0, w_points};

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    tick_d     = tick_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rd_id_d    = '0;
    cur_note_d = '0;
    score_d    = score_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
`ifdef CHART_PLAY_COMBO_EN
    combo_d    = combo_q;
    maxc_d     = maxc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && (chart_id != 8'd0)) begin
          state_d = S_LOAD;
          rd_id_d = chart_id;
          ld_d    = '0;
          idx_d   = '0;
          score_d = '0;
          hit_d   = '0;
          miss_d  = '0;
`ifdef CHART_PLAY_COMBO_EN
          combo_d = '0;
          maxc_d  = '0;
`endif
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (ld_q == LD_LAST) begin
          cnt_d   = note_cnt;
          idx_d   = '0;
          tick_d  = '0;
          state_d = (note_cnt == '0) ? S_FINISH : S_PLAY;
        end else begin
          ld_d    = ld_q + LD_W'(1);
          rd_id_d = rd_id_q;
        end
      end
      S_PLAY: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cur_note_d = note_data;
          if (w_eval) begin
            if (w_hit) begin
              hit_d   = hit_q + IDX_W'(1);
              score_d = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
`ifdef CHART_PLAY_COMBO_EN
              combo_d = combo_q + IDX_W'(1);
              if (combo_d > maxc_q) maxc_d = combo_d;
`endif
            end else if (note_data != '0) begin
              miss_d  = miss_q + IDX_W'(1);
`ifdef CHART_PLAY_COMBO_EN
              combo_d = '0;
`endif
            end
            if (w_last) begin
              state_d    = S_FINISH;
              cur_note_d = '0;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
              tick_d = '0;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      ld_q       <= '0;
      tick_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_id_q    <= '0;
      cur_note_q <= '0;
      score_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
`ifdef CHART_PLAY_COMBO_EN
      combo_q    <= '0;
      maxc_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_id_q    <= rd_id_d;
      cur_note_q <= cur_note_d;
      score_q    <= score_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
`ifdef CHART_PLAY_COMBO_EN
      combo_q    <= combo_d;
      maxc_q     <= maxc_d;
`endif
    end
  end

  assign read_chart_id = rd_id_q;
  assign note_idx      = idx_q;
  assign cur_note      = cur_note_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_PLAY);
  assign done          = (state_q == S_FINISH);
  assign score         = score_q;
  assign hit_cnt       = hit_q;
  assign miss_cnt      = miss_q;
`ifdef CHART_PLAY_COMBO_EN
  assign max_combo     = maxc_q;
`else
  assign max_combo     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chart_play_sequencer.sv
// Directed table-driven bench for chart_play_sequencer with TICK_DIV=4 and a simple chart storage model.
`default_nettype none

module tb_chart_play_sequencer;

`ifdef CHART_PLAY_COMBO_EN
  localparam bit COMBO = 1'b1;
`else
  localparam bit COMBO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] chart_id = '0;
  logic       abort = 1'b0;
  logic [8:0] note_cnt = '0;
  logic [8:0] note_data;
  logic [8:0] keys_in = '0;
  logic [7:0] read_chart_id;
  logic [8:0] note_idx;
  logic [8:0] cur_note;
  logic       busy;
  logic       done;
  logic [15:0] score;
  logic [8:0] hit_cnt;
  logic [8:0] miss_cnt;
  logic [8:0] max_combo;

  logic [8:0] mem [0:15];
  int errors = 0;
  int checks = 0;

  assign note_data = mem[note_idx[3:0]];

  always #5 clk = ~clk;

  chart_play_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .chart_id(chart_id),
    .abort(abort), .note_cnt(note_cnt), .note_data(note_data), .keys_in(keys_in),
    .read_chart_id(read_chart_id), .note_idx(note_idx), .cur_note(cur_note),
    .busy(busy), .done(done), .score(score), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt), .max_combo(max_combo)
  );

  typedef struct {
    logic [7:0]      chart;
    logic [8:0]      cnt;
    logic [7:0][8:0] notes;
    logic [8:0]      keys;
    int              score;
    int              score_c;
    int              hit;
    int              miss;
    int              maxc;
    int              lat;
    int              nbusy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_play(input logic [7:0] id);
    chart_id = id;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chart_id = '0;
  endtask

  task automatic load_notes(input logic [8:0] cnt, input logic [7:0][8:0] n, input logic [8:0] k);
    for (int i = 0; i < 8; i++) mem[i] = n[i];
    note_cnt = cnt;
    keys_in  = k;
  endtask

  task automatic count_done(input int cycles, output int ndone);
    ndone = 0;
    for (int c = 0; c < cycles; c++) begin
      if (done) ndone++;
      step();
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int ndone, nbusy, lat;
    load_notes(v.cnt, v.notes, v.keys);
    start_play(v.chart);
    ndone = 0; nbusy = 0; lat = 0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      step();
    end
    chk($sformatf("v%0d done_pulses", n), ndone, 1);
    chk($sformatf("v%0d done_latency", n), lat, v.lat);
    chk($sformatf("v%0d busy_cycles", n), nbusy, v.nbusy);
    chk($sformatf("v%0d score", n), score, COMBO ? v.score_c : v.score);
    chk($sformatf("v%0d hit_cnt", n), hit_cnt, v.hit);
    chk($sformatf("v%0d miss_cnt", n), miss_cnt, v.miss);
    chk($sformatf("v%0d max_combo", n), max_combo, COMBO ? v.maxc : 0);
  endtask

  initial begin
    int nd;
    vecs[0] = '{chart: 8'd1, cnt: 9'd3, notes: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h001, 9'h001, 9'h001},
                keys: 9'h001, score: 30, score_c: 33, hit: 3, miss: 0, maxc: 3, lat: 15, nbusy: 14};
    vecs[1] = '{chart: 8'd2, cnt: 9'd3, notes: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h020, 9'h000, 9'h010},
                keys: 9'h010, score: 10, score_c: 10, hit: 1, miss: 1, maxc: 1, lat: 15, nbusy: 14};
    vecs[2] = '{chart: 8'd3, cnt: 9'd0, notes: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h001},
                keys: 9'h001, score: 0, score_c: 0, hit: 0, miss: 0, maxc: 0, lat: 3, nbusy: 2};
    vecs[3] = '{chart: 8'd4, cnt: 9'd2, notes: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h008, 9'h004},
                keys: 9'h000, score: 0, score_c: 0, hit: 0, miss: 2, maxc: 0, lat: 11, nbusy: 10};
    vecs[4] = '{chart: 8'd5, cnt: 9'd1, notes: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h100},
                keys: 9'h100, score: 10, score_c: 10, hit: 1, miss: 0, maxc: 1, lat: 7, nbusy: 6};
    vecs[5] = '{chart: 8'd6, cnt: 9'd7, notes: {9'h0, 9'h001, 9'h002, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001},
                keys: 9'h001, score: 60, score_c: 70, hit: 6, miss: 1, maxc: 5, lat: 31, nbusy: 30};
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst read_chart_id", read_chart_id, 0);
    chk("rst busy_done", {busy, done}, 0);
    chk("rst score", score, 0);
    chk("rst idx_note", {note_idx, cur_note}, 0);
    chk("rst counters", {hit_cnt, miss_cnt, max_combo}, 0);
    sys_rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Read-request timing, cur_note loading, then abort in slot 1
    load_notes(9'd3, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h004, 9'h002, 9'h001}, 9'h001);
    start_play(8'd6);
    chk("ab rd_e1", read_chart_id, 6);
    chk("ab cleared_on_start", {score, hit_cnt, miss_cnt}, 0);
    step();
    chk("ab rd_e2", read_chart_id, 6);
    step();
    chk("ab rd_e3", read_chart_id, 0);
    chk("ab busy_play", busy, 1);
    step();
    chk("ab cur_note", cur_note, 9'h001);
    repeat (3) step();
    chk("ab idx_slot1", note_idx, 1);
    chk("ab hit_slot0", hit_cnt, 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab busy_fell", busy, 0);
    chk("ab idx_hold", note_idx, 1);
    chk("ab rd_zero", read_chart_id, 0);
    chk("ab cur_note_zero", cur_note, 0);
    chk("ab score_hold", score, 10);
    count_done(8, nd);
    chk("ab no_done", nd, 0);

    // New chart after abort clears counters
    load_notes(9'd1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h001}, 9'h000);
    start_play(8'd8);
    chk("new score_clr", score, 0);
    chk("new hit_clr", hit_cnt, 0);
    count_done(20, nd);
    chk("new done", nd, 1);
    chk("new miss", miss_cnt, 1);

    // Abort on the final evaluation cycle wins
    load_notes(9'd1, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h001}, 9'h001);
    start_play(8'd9);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abw busy", busy, 0);
    chk("abw hit", hit_cnt, 0);
    chk("abw score", score, 0);
    count_done(8, nd);
    chk("abw no_done", nd, 0);

    // start during PLAY is ignored; start with chart_id 0 in IDLE is ignored
    load_notes(9'd2, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h001, 9'h001}, 9'h001);
    start_play(8'd10);
    repeat (3) step();
    chart_id = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    chart_id = '0;
    chk("sp rd_zero", read_chart_id, 0);
    chk("sp idx", note_idx, 0);
    count_done(30, nd);
    chk("sp done", nd, 1);
    chk("sp score", score, 20);
    chk("sp hit", hit_cnt, 2);
    chart_id = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("z busy", busy, 0);
    chk("z rd", read_chart_id, 0);
    chk("z score_hold", score, 20);

    // Asynchronous reset mid-PLAY
    load_notes(9'd3, {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h001, 9'h001, 9'h001}, 9'h001);
    start_play(8'd11);
    repeat (7) step();
    chk("rr pre_score", score, 10);
    #2 sys_rst = 1'b1;
    #1;
    chk("rr busy", busy, 0);
    chk("rr score", score, 0);
    chk("rr hit", hit_cnt, 0);
    chk("rr idx_note", {note_idx, cur_note}, 0);
    chk("rr rd", read_chart_id, 0);
    #2 sys_rst = 1'b0;
    count_done(20, nd);
    chk("rr no_done", nd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
